// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin mux arbiter.
// The master side drives requests; the slave (arbiter) side drives grant, select, busy and FSM state.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       dbg_state;

  modport master (output req, input gnt, sel, busy, dbg_state);
  modport slave  (input req, output gnt, sel, busy, dbg_state);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair and one-hot grant of a 4:1 mux.
// Grants are bounded by HOLD_MAX cycles; release and re-arbitration share one edge.
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux4_rr_arbiter_if.slave bus
);

  // Handshake: req is a level, gnt/sel/busy are registered and change only on
  // the rising edge after the requests that caused them were sampled.
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_e;

  state_e           state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       sel_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic             any_req;
  logic             release_w;
  logic [1:0]       base_w;
  logic [1:0]       winner_w;

  // First requester strictly after p, wrapping so p itself is tried last.
  function automatic logic [1:0] search(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] idx;
    search = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) search = idx;
    end
  endfunction

  always_comb begin
    any_req   = |bus.req;
    release_w = !bus.req[sel_q] || (cnt_q == CNT_W'(HOLD_MAX));
    base_w    = (state_q == S_GRANT) ? sel_q : ptr_q;
    winner_w  = search(base_w, bus.req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q <= S_GRANT;
            gnt_q   <= 4'b0001 << winner_w;
            sel_q   <= winner_w;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (!release_w) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            ptr_q <= sel_q;
            // Searching from the old owner lets it win only when nobody else waits.
            if (any_req) begin
              gnt_q <= 4'b0001 << winner_w;
              sel_q <= winner_w;
              cnt_q <= CNT_W'(1);
            end else begin
              state_q <= S_IDLE;
              gnt_q   <= 4'b0000;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = (state_q == S_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (HOLD_MAX 8 and 1) driven with directed
// and random requests, scored against an owner/count/pointer model of the arbiter.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   started;

  logic [6:0] exp_q8[$];
  logic [6:0] exp_q1[$];

  mux4_rr_arbiter_if bus8();
  mux4_rr_arbiter_if bus1();

  mux4_rr_arbiter #(.HOLD_MAX(8), .CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  mux4_rr_arbiter #(.HOLD_MAX(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Index 0 models the HOLD_MAX=8 instance, index 1 the HOLD_MAX=1 instance.
  int m_owner[2];
  int m_cnt[2];
  int m_ptr[2];
  int m_sel[2];
  int m_hold[2] = '{8, 1};

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [6:0] model_step(input int d, input logic r_in, input logic [3:0] req);
    logic [3:0] g;
    logic [1:0] s;
    if (r_in) begin
      m_owner[d] = -1; m_cnt[d] = 0; m_ptr[d] = 3; m_sel[d] = 0;
    end else if (m_owner[d] < 0) begin
      if (req != 4'b0) begin
        m_owner[d] = pick(m_ptr[d], req); m_cnt[d] = 1; m_sel[d] = m_owner[d];
      end
    end else if (!req[m_owner[d]] || m_cnt[d] == m_hold[d]) begin
      m_ptr[d] = m_owner[d];
      if (req != 4'b0) begin
        m_owner[d] = pick(m_ptr[d], req); m_cnt[d] = 1; m_sel[d] = m_owner[d];
      end else begin
        m_owner[d] = -1;
      end
    end else begin
      m_cnt[d] = m_cnt[d] + 1;
    end
    g = (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
    s = 2'(m_sel[d]);
    return {g, s, (m_owner[d] >= 0)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r_in, input logic [3:0] req8, input logic [3:0] req1);
    @(negedge clk);
    rst      = r_in;
    bus8.req = req8;
    bus1.req = req1;
    exp_q8.push_back(model_step(0, r_in, req8));
    exp_q1.push_back(model_step(1, r_in, req1));
    started = 1'b1;
  endtask

  task automatic rand_drive(input logic r_in, input logic [3:0] req8);
    drive(r_in, req8, 4'($urandom_range(0, 15)));
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check_out(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b busy=%b at %0t",
               name, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0], $time);
    end
  endtask

  task automatic check_inv(input string name, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic st);
    logic ok;
    ok = ($countones(g) <= 1) && (b == (g != 4'b0)) && (st == b) &&
         (!b || g[s]);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s invariant: gnt=%b sel=%b busy=%b state=%b at %0t", name, g, s, b, st, $time);
    end
  endtask

  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q8.size() > 0) begin
        e = exp_q8.pop_front();
        check_out("dut8", {bus8.gnt, bus8.sel, bus8.busy}, e);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check_out("dut1", {bus1.gnt, bus1.sel, bus1.busy}, e);
      end
      if (started) begin
        check_inv("dut8", bus8.gnt, bus8.sel, bus8.busy, bus8.dbg_state);
        check_inv("dut1", bus1.gnt, bus1.sel, bus1.busy, bus1.dbg_state);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wait_cnt;
    checks   = 0;
    errors   = 0;
    started  = 1'b0;
    rst      = 1'b1;
    bus8.req = 4'b0000;
    bus1.req = 4'b0000;

    // Reset held with all requests high, then full contention across four hold windows.
    rand_drive(1'b1, 4'b1111);
    rand_drive(1'b1, 4'b1111);
    for (int i = 0; i < 34; i++) rand_drive(1'b0, 4'b1111);

    // Single requester across two timeouts.
    for (int i = 0; i < 20; i++) rand_drive(1'b0, 4'b0100);

    // Owner 0 drops early, handover to 1 without bubble, then all drop.
    for (int i = 0; i < 4; i++) rand_drive(1'b0, 4'b0011);
    for (int i = 0; i < 2; i++) rand_drive(1'b0, 4'b0010);
    for (int i = 0; i < 3; i++) rand_drive(1'b0, 4'b0000);

    // Reset in the middle of a grant to requester 2.
    for (int i = 0; i < 3; i++) rand_drive(1'b0, 4'b0100);
    rand_drive(1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) rand_drive(1'b0, 4'b1111);

    // Random traffic on both instances.
    for (int i = 0; i < 64; i++) rand_drive(1'b0, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 4; i++) rand_drive(1'b0, 4'b0000);

    wait_cnt = 0;
    while ((exp_q8.size() > 0 || exp_q1.size() > 0) && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    checks++;
    if (exp_q8.size() > 0 || exp_q1.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", exp_q8.size(), exp_q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 mux output between four requesters. It drives the mux select pair (S1, S2) and a one-hot grant vector so that exactly one requester owns the mux at a time. Grant length is bounded by a hold limit, so no requester can starve the others. It sits directly in front of the 4x1 mux: sel[1] drives S1 and sel[0] drives S2.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles one requester may hold a grant (legal range 1..255; 1 means rotate every cycle)
CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_MAX

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request lines; req[i] high means requester i wants the mux
gnt  output 4  one-hot grant, registered; all zero when idle
sel  output 2  mux select index, registered; sel[1] drives S1, sel[0] drives S2
busy output 1  high while any grant is active (equals |gnt)

Behaviour:
- Reset (rst high at a clock edge):
  - gnt=0000, sel=00, busy=0.
  - State goes to IDLE, hold counter=0, last-owner pointer ptr=3, so requester 0 has top priority first.
  - rst overrides all other inputs, including mid-grant; the grant drops on that same edge.
- Priority search: from a given pointer p, scan indices p+1, p+2, p+3, p+4 (all mod 4). The first index with req set wins.
- States: IDLE and GRANT.
- IDLE:
  - If req != 0, the next edge enters GRANT with owner = search(ptr).
  - On that edge: gnt = onehot(owner), sel = owner, busy=1, counter=1.
  - Latency from req sampled high to gnt high is 1 cycle.
  - If req == 0, stay in IDLE; sel holds its last value.
- GRANT, release condition = req[owner]==0 OR counter==HOLD_MAX, evaluated at each edge.
  - Release not met: keep owner, counter increments.
  - Release met: ptr becomes owner, then re-arbitrate on the same edge:
    - If another requester is pending, it is granted immediately with counter=1. No idle bubble between owners.
    - If only the owner still requests (timeout case), regrant to the owner with counter=1. gnt stays continuously high.
    - If req == 0, go to IDLE: gnt=0000, busy=0, sel holds last value.
- Invariants:
  - gnt is always zero or one-hot.
  - sel always equals the index of the set gnt bit whenever busy=1.
  - gnt never changes except on a clock edge.
- Simultaneous events: a new request arriving on the same edge as a release takes part in that edge's arbitration.
- Counter width: the counter never exceeds HOLD_MAX and does not wrap.
- X handling: an X on req is not required to be handled; the bench drives only 0/1.

Test Plan:
1. Reset with req=1111 held 2 cycles -> gnt=0000, sel=00, busy=0 throughout. On the first edge after rst falls: gnt=0001, sel=00.
2. req=1111 continuous, HOLD_MAX=8 -> gnt cycles 0001, 0010, 0100, 1000, 8 cycles each; sel steps 00, 01, 10, 11. No cycle with gnt=0000.
3. Only req=0100 held 20 cycles -> gnt=0100 and sel=10 stay constant across both timeouts; busy stays 1.
4. req=0011 and owner 0 drops req[0] after 3 cycles -> the following edge gives gnt=0010, sel=01, with no idle cycle. Then drop all req -> next edge gnt=0000, busy=0, sel stays 01.
5. Reset mid-grant: owner 2 active, rst high for 1 cycle with req=1111 -> gnt=0000 on that edge. The next edge grants requester 0, not 3.
6. HOLD_MAX=1 with random req over 64 patterns, checked against a behavioural reference model each cycle -> exact gnt/sel/busy match; one-hot and sel==index invariants hold every cycle.
